dec_gray2bin: RTL
=================

DEC_GRAY2BIN -- requirements
Module: dec_gray2bin

Interface
REQ-001 The module SHALL have parameter WIDTH, default 10: code width in bits; legal range 1..32.
REQ-002 Port clk SHALL be an input, 1 bit wide: the single clock; all state is updated on its rising edge.
REQ-003 Port rst_n SHALL be an input, 1 bit wide: the reset, asynchronous and active-low.
REQ-004 Port gray SHALL be an input, WIDTH bits wide: the Gray-coded word, sampled only on an input handshake.
REQ-005 Port in_valid SHALL be an input, 1 bit wide: gray carries a valid word.
REQ-006 Port in_ready SHALL be an output, 1 bit wide: the decoder can accept a word.
REQ-007 Port bin SHALL be an output, WIDTH bits wide: the decoded binary word.
REQ-008 Port out_valid SHALL be an output, 1 bit wide: bin holds a completed result.
REQ-009 Port out_ready SHALL be an input, 1 bit wide: the consumer accepts bin.

Function
REQ-010 The decoder SHALL be a bit-serial Gray-to-binary decoder with states IDLE, BUSY and HOLD.
REQ-011 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in HOLD; both SHALL be driven by registers or the state register only.
REQ-012 An input handshake SHALL occur on a rising edge with in_valid=1 and in_ready=1.
- gray is captured into an internal register.
- bin[WIDTH-1] = gray[WIDTH-1].
- Bit index idx = WIDTH-2.
- Next state is BUSY, or HOLD if WIDTH=1.
REQ-013 Each BUSY edge SHALL compute bin[idx] = bin[idx+1] XOR gray_reg[idx].
- If idx=0, the next state is HOLD.
- Otherwise idx decrements.
REQ-014 Latency SHALL be exactly WIDTH-1 rising edges from the accepting edge to out_valid=1: 9 cycles for WIDTH=10.
REQ-015 In HOLD, bin SHALL stay stable until an output handshake (out_valid=1 and out_ready=1); on that edge the next state is IDLE.
REQ-016 in_valid and gray SHALL be ignored outside IDLE; the captured word SHALL be unaffected by input changes after capture.
REQ-017 A new word SHALL not be accepted on the HOLD-exit edge; minimum spacing between accepts is WIDTH+1 cycles with out_ready held at 1.
REQ-018 out_ready asserted outside HOLD SHALL have no effect.
REQ-019 bin bits not yet computed during BUSY are don't-care; only the value while out_valid=1 is specified.
REQ-020 The result SHALL equal the prefix XOR: bin[i] = XOR of gray[WIDTH-1:i], for every i.

Reset
REQ-021 Assertion of rst_n=0 SHALL immediately, regardless of clk, force:
- state = IDLE, idx = 0;
- bin = 0, gray_reg = 0;
- out_valid = 0, in_ready = 1.
REQ-022 A reset during BUSY or HOLD SHALL discard the word in progress; no out_valid pulse SHALL follow the reset.
REQ-023 Release of rst_n SHALL be synchronised by the integrating level; the first accept is allowed on the first rising edge with rst_n=1.

Structure
REQ-024 Package gray2bin_pkg SHALL hold the state enum (IDLE, BUSY, HOLD) and the default WIDTH constant.
REQ-025 The index counter width SHALL be $clog2(WIDTH) with a minimum of 1 bit.
REQ-026 The RTL SHALL be a single module with no sub-module.
REQ-027 The bench SHALL instantiate the existing enc_bin2gray encoder as its stimulus and reference model.

Verification
REQ-028 Reset with idle bus -> in_ready=1, out_valid=0, bin=10'h000.
REQ-029 gray=10'h3FF accepted -> out_valid rises 9 edges later with bin=10'h2AA; gray=10'h155 -> bin=10'h199; gray=10'h200 -> bin=10'h3FF.
REQ-030 out_ready held 0 for 20 cycles in HOLD -> bin and out_valid stable and in_ready=0; out_ready=1 -> IDLE on the next edge.
REQ-031 gray toggled and in_valid held 1 during BUSY -> result unchanged; the next accept occurs only once IDLE is re-entered.
REQ-032 rst_n pulsed low mid-BUSY after accepting gray=10'h3FF -> out_valid=0 and bin=0 immediately; no later output for that word.
REQ-033 Exhaustive round trip: all 1024 bin values through enc_bin2gray into dec_gray2bin with random out_ready stalls -> every output equals the original value, in order; repeat with WIDTH=1 (latency 0).

Source files
------------

// File: rtl/gray2bin_pkg.sv
// Purpose: shared types and defaults for the bit-serial Gray-to-binary decoder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package gray2bin_pkg;

    // Decoder control states: waiting for a word, shifting bits out, result on hold
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        HOLD = 2'd2
    } state_t;

    // Default code width of the decoder
    localparam int GRAY2BIN_WIDTH = 10;

endpackage

// File: rtl/enc_bin2gray.sv
// Purpose: combinational binary-to-Gray encoder (gray = bin ^ (bin >> 1)).
// Latency: 0 cycles, purely combinational.
// Backpressure: none; output follows input.
module enc_bin2gray #(
    parameter int WIDTH = 10
) (
    input  logic [WIDTH-1:0] bin,
    output logic [WIDTH-1:0] gray
);

    assign gray = bin ^ (bin >> 1);

endmodule

// File: rtl/dec_gray2bin.sv
// Purpose: bit-serial Gray-to-binary decoder, one result bit per cycle from the MSB down.
// Latency: WIDTH-1 rising edges from the accepting edge to out_valid.
// Backpressure: in_ready only in IDLE; result held in HOLD until out_ready, no accept on the exit edge.
module dec_gray2bin
    import gray2bin_pkg::*;
#(
    parameter int WIDTH = GRAY2BIN_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] gray,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] bin,
    output logic             out_valid,
    input  logic             out_ready
);

    // Index counter is at least one bit so WIDTH=1 still elaborates cleanly
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int IDX_TOP_I = (WIDTH > 1) ? WIDTH - 2 : 0;
    localparam logic [IW-1:0] IDX_TOP = IDX_TOP_I[IW-1:0];
    localparam logic [WIDTH-1:0] LSB_ONE = WIDTH'(1);

    state_t           state_q;
    state_t           state_d;
    logic [IW-1:0]    idx_q;
    logic [WIDTH-1:0] gray_q;
    logic [WIDTH-1:0] bin_q;
    logic [WIDTH-1:0] bin_nxt;
    logic [WIDTH-1:0] bit_sel;
    logic             accept;

    // Handshake flags come straight from the state register
    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == HOLD);
    assign bin       = bin_q;
    assign accept    = in_valid && in_ready;

    // Candidate bits: bit i = bin[i+1] ^ gray_reg[i]; only the bit at idx is committed
    assign bin_nxt = (bin_q >> 1) ^ gray_q;
    assign bit_sel = LSB_ONE << idx_q;

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = (WIDTH == 1) ? HOLD : BUSY;
                end
            end
            BUSY: begin
                if (idx_q == '0) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Capture on accept, then resolve one bit per BUSY edge walking towards the LSB
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q  <= '0;
            gray_q <= '0;
            bin_q  <= '0;
        end else if (accept) begin
            gray_q           <= gray;
            bin_q[WIDTH-1]   <= gray[WIDTH-1];
            idx_q            <= IDX_TOP;
        end else if (state_q == BUSY) begin
            bin_q <= (bin_q & ~bit_sel) | (bin_nxt & bit_sel);
            if (idx_q != '0) begin
                idx_q <= idx_q - IW'(1);
            end
        end
    end

endmodule
